imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-side memory with a host byte loader and a start-gating state machine. It sits directly upstream of the single-cycle DATA_PATH. It is written byte-by-byte from the host port (PC_to_mem_*) while the core is held. It releases the core on a debounced start-button press. After release it serves `instruction` combinationally for the current `PC`, together with `execution_enable`.

## Interface
- `MEM_BYTES`, 4096: instruction storage size in bytes; power of two, at least 4.
- `INS_START_ADDRESS`, 32'h0000_0000: byte address of storage location 0. Equals the core's PC reset value.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to change the debounced button level; at least 1.
- `SYS_clk`  in  1  sole clock; all state updates on its rising edge.
- `SYS_reset`  in  1  synchronous, active-high reset.
- `SYS_start_button`  in  1  raw asynchronous push button.
- `PC_to_mem_enable`  in  1  host byte-write strobe, one byte per cycle.
- `PC_to_mem_data`  in  8  host byte.
- `PC_to_mem_address`  in  32  host absolute byte address.
- `PC`  in  32  fetch address from the core.
- `instruction`  out  32  fetched word, combinational from `PC`.
- `execution_enable`  out  1  high only in state RUN.
- `load_error`  out  1  sticky flag for a rejected host write.
- `run_cycles`  out  32  cycles spent in RUN; saturates at 32'hFFFF_FFFF.

## Operation
- States: LOAD (reset state) and RUN. There is no other path out of RUN except `SYS_reset`.
- **LOAD:**
  - Host write accepted when `PC_to_mem_enable`=1 and `INS_START_ADDRESS` ≤ address < `INS_START_ADDRESS`+`MEM_BYTES`.
  - An accepted write stores the byte at offset address−`INS_START_ADDRESS` on the edge.
  - An out-of-range write is dropped and sets `load_error`.
- **RUN:**
  - Every host write is dropped and sets `load_error`.
  - Storage is read-only from the host side.
- **LOAD→RUN:** taken on the edge where the debounced button level changes 0→1.
  - A host write in that same cycle is still accepted, because the state is LOAD at that edge.
- **Button path:**
  - Two-flop synchronizer (s1, s2) followed by the debouncer (counter cnt, level deb).
  - When s2==deb: cnt←0.
  - When s2!=deb and cnt==`DEBOUNCE_CYCLES`−1: deb←s2 and cnt←0.
  - Otherwise cnt←cnt+1.
  - The button's falling edge updates deb but has no other effect.
- **Fetch:**
  - `instruction` = little-endian {mem[o+3], mem[o+2], mem[o+1], mem[o]}, with o = PC−`INS_START_ADDRESS`.
  - Valid only if PC[1:0]==0 and `INS_START_ADDRESS` ≤ PC ≤ `INS_START_ADDRESS`+`MEM_BYTES`−4.
  - Otherwise `instruction`=32'h0000_0000. Opcode 0 is invalid, so the core freezes its PC.
  - Fetch is independent of state, so a bench may read back contents during LOAD.
- **`run_cycles`:** cleared in LOAD; increments by 1 on every edge while in RUN; holds at all-ones.
- **Reset values:**
  - state=LOAD, `execution_enable`=0, `load_error`=0, `run_cycles`=0.
  - s1=s2=deb=0, cnt=0.
- **Storage contents:** not cleared by reset and undefined at power-up. A reset mid-run therefore returns to LOAD with the program intact, and the start button must be pressed again to re-run.

## Timing
- Host write latency: the byte is visible on `instruction` in the cycle after its edge.
- Fetch latency: zero cycles; `instruction` is purely combinational from `PC` and storage.
- `load_error` rises on the edge that samples the rejected write.
- **Start latency:**
  - Button sampled high on edge E0 (s1=1); s2=1 at E1.
  - deb and state change at edge E1+`DEBOUNCE_CYCLES`.
  - With `DEBOUNCE_CYCLES`=4, `execution_enable` is high after E5.
  - The button must be held for at least `DEBOUNCE_CYCLES`+2 edges.
  - A glitch shorter than `DEBOUNCE_CYCLES` stable s2 samples never changes deb.
- The first RUN cycle presents PC=`INS_START_ADDRESS`, because the core's PC is held by `execution_enable`=0 during LOAD.
- **`SYS_reset` precedence:**
  - `SYS_reset` asserted in the same cycle as a host write or a start transition wins over both.
  - The write is not performed and the state stays LOAD.

## Test plan
- **Load and fetch:**
  - Stimulus: reset, then write bytes 13,05,A0,00 to addresses 0..3.
  - Required: `instruction`=32'h00A0_0513 at PC=0; `execution_enable`=0; `load_error`=0.
- **Start debounce** (`DEBOUNCE_CYCLES`=4):
  - Stimulus: hold the button high for 3 cycles, then drop it.
  - Required: `execution_enable` stays 0.
  - Stimulus: hold the button high for 6 cycles.
  - Required: `execution_enable`=1 after the 6th edge; `run_cycles` reads 1 one edge later.
- **Rejected writes:**
  - Stimulus: in LOAD, write address `MEM_BYTES`.
  - Required: `load_error`=1 and memory unchanged.
  - Stimulus: in RUN, write address 0 with 8'hFF.
  - Required: word 0 unchanged.
- **Fetch edge cases:**
  - PC=2 → 0.
  - PC=`MEM_BYTES`−4 → last stored word.
  - PC=`MEM_BYTES` → 0.
- **Reset mid-run:**
  - Stimulus: assert `SYS_reset` after 10 RUN cycles.
  - Required: state LOAD, `run_cycles`=0, `load_error`=0, and word 0 still 32'h00A0_0513.
  - Required: a second valid button press restarts the core.
- **Simultaneous events:**
  - Stimulus: a host write to address 4 on the LOAD→RUN edge.
  - Required: the byte is stored.
  - Stimulus: the same write with `SYS_reset`=1.
  - Required: the byte is not stored.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: host byte-loadable instruction memory that holds the core in LOAD
// until a debounced start press, then serves fetches and counts RUN cycles.
module imem_loader #(
  parameter int unsigned MEM_BYTES         = 4096,
  parameter logic [31:0] INS_START_ADDRESS = 32'h0000_0000,
  parameter int unsigned DEBOUNCE_CYCLES   = 4
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        SYS_start_button,
  input  logic        PC_to_mem_enable,
  input  logic [7:0]  PC_to_mem_data,
  input  logic [31:0] PC_to_mem_address,
  input  logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        execution_enable,
  output logic        load_error,
  output logic [31:0] run_cycles
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {LOAD, RUN} state_t;
  state_t r_state, w_state_n;
  logic r_s1, r_s2, r_deb, r_err;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_run_cycles;
  logic [7:0] r_mem [MEM_BYTES];
  logic [31:0] w_woff, w_foff;
  logic w_wr_ok, w_deb_flip, w_fetch_ok;
  // Offsets wrap below the base, so one unsigned compare covers both bounds.
  assign w_woff = PC_to_mem_address - INS_START_ADDRESS;
  assign w_foff = PC - INS_START_ADDRESS;
  assign w_wr_ok = PC_to_mem_enable && r_state == LOAD && w_woff < MEM_BYTES;
  assign w_deb_flip = (r_s2 != r_deb) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_fetch_ok = PC[1:0] == 2'b00 && w_foff <= MEM_BYTES - 4;
  assign instruction = w_fetch_ok ? {r_mem[{w_foff[AW-1:2], 2'd3}], r_mem[{w_foff[AW-1:2], 2'd2}],
                                     r_mem[{w_foff[AW-1:2], 2'd1}], r_mem[{w_foff[AW-1:2], 2'd0}]} : 32'h0;
  assign load_error = r_err;
  assign run_cycles = r_run_cycles;
  always_comb begin
    w_state_n = (r_state == LOAD && w_deb_flip && r_s2) ? RUN : r_state;
    execution_enable = r_state == RUN;
  end
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state      <= LOAD;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_deb        <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_run_cycles <= '0;
    end else begin
      r_state      <= w_state_n;
      r_s1         <= SYS_start_button;
      r_s2         <= r_s1;
      r_deb        <= w_deb_flip ? r_s2 : r_deb;
      r_cnt        <= (r_s2 == r_deb || w_deb_flip) ? '0 : r_cnt + 1'b1;
      r_err        <= r_err | (PC_to_mem_enable & ~w_wr_ok);
      r_run_cycles <= (r_state == LOAD) ? '0 : r_run_cycles + {31'd0, ~&r_run_cycles};
    end
  end
  // Storage has no reset so a mid-run reset keeps the loaded program.
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset && w_wr_ok) r_mem[w_woff[AW-1:0]] <= PC_to_mem_data;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a behavioural model checked every cycle
// plus literal expectations for the key scenarios.
module tb_imem_loader;
  localparam int MB = 4096;
  localparam int DC = 4;
  logic clk = 0, rst = 1, btn = 0, wen = 0;
  logic [7:0] wdat = 0;
  logic [31:0] waddr = 0, pc = 0;
  logic [31:0] ins, rc;
  logic ee, le;
  int total = 0, bad = 0;
  bit mon_on = 0;

  imem_loader #(.MEM_BYTES(MB), .INS_START_ADDRESS(32'h0), .DEBOUNCE_CYCLES(DC)) dut (
    .SYS_clk(clk), .SYS_reset(rst), .SYS_start_button(btn),
    .PC_to_mem_enable(wen), .PC_to_mem_data(wdat), .PC_to_mem_address(waddr),
    .PC(pc), .instruction(ins), .execution_enable(ee), .load_error(le), .run_cycles(rc));

  always #5 clk = ~clk;

  logic [7:0] m_mem [MB];
  bit m_known [MB];
  bit m_run, m_err, m_deb, flip;
  logic [31:0] m_rc;
  bit bq[$];
  int l;

  // Model: deb flips once the last DC synchronized samples (button two edges late) all differ from it.
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_err = 0; m_rc = 0; m_deb = 0;
      bq.delete();
      for (int i = 0; i < DC + 2; i++) bq.push_back(1'b0);
    end else begin
      l = bq.size();
      flip = 1;
      for (int i = 0; i < DC; i++) if (bq[l-2-i] == m_deb) flip = 0;
      if (wen) begin
        if (!m_run && waddr < MB) begin
          m_mem[waddr[11:0]] = wdat;
          m_known[waddr[11:0]] = 1;
        end else m_err = 1;
      end
      m_rc = m_run ? ((m_rc == 32'hFFFF_FFFF) ? m_rc : m_rc + 1) : 32'h0;
      if (flip) begin
        m_deb = !m_deb;
        if (m_deb) m_run = 1;
      end
      bq.push_back(btn);
      void'(bq.pop_front());
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("model_ee", {31'd0, ee}, {31'd0, m_run});
      chk("model_le", {31'd0, le}, {31'd0, m_err});
      chk("model_rc", rc, m_rc);
      if (pc[1:0] != 2'b00 || pc > MB - 4) chk("model_ins_zero", ins, 32'h0);
      else if (m_known[pc[11:0]] && m_known[pc[11:0]+1] && m_known[pc[11:0]+2] && m_known[pc[11:0]+3])
        chk("model_ins", ins, {m_mem[pc[11:0]+3], m_mem[pc[11:0]+2], m_mem[pc[11:0]+1], m_mem[pc[11:0]]});
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [31:0] a, logic [7:0] d);
    wen = 1; waddr = a; wdat = d;
    step(1);
    wen = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    mon_on = 1;
    step(1);
    rst = 0;
    chk("reset_ee", {31'd0, ee}, 32'd0);
    chk("reset_le", {31'd0, le}, 32'd0);
    chk("reset_rc", rc, 32'd0);
    for (int i = 0; i < MB; i++) wr(i, 8'(i * 37 + 11));
    wr(0, 8'h13); wr(1, 8'h05); wr(2, 8'hA0); wr(3, 8'h00);
    wr(4092, 8'h78); wr(4093, 8'h56); wr(4094, 8'h34); wr(4095, 8'h12);
    pc = 0; #1;
    chk("load_word0", ins, 32'h00A0_0513);
    chk("load_ee", {31'd0, ee}, 32'd0);
    chk("load_le", {31'd0, le}, 32'd0);
    pc = 2; #1;
    chk("fetch_misaligned", ins, 32'h0);
    pc = MB - 4; #1;
    chk("fetch_last", ins, 32'h1234_5678);
    pc = MB; #1;
    chk("fetch_past_end", ins, 32'h0);
    wr(MB, 8'h55);
    chk("oor_le", {31'd0, le}, 32'd1);
    pc = 0; #1;
    chk("oor_word0", ins, 32'h00A0_0513);
    btn = 1; step(3); btn = 0; step(10);
    chk("glitch_ee", {31'd0, ee}, 32'd0);
    btn = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin wen = 1; waddr = 4; wdat = 8'hC3; end
      step(1);
      wen = 0;
    end
    chk("start_ee", {31'd0, ee}, 32'd1);
    chk("start_rc0", rc, 32'd0);
    pc = 4; #1;
    chk("edge_write_byte", {24'd0, ins[7:0]}, 32'h0000_00C3);
    btn = 0;
    step(1);
    chk("rc_one", rc, 32'd1);
    wr(0, 8'hFF);
    chk("run_write_le", {31'd0, le}, 32'd1);
    pc = 0; #1;
    chk("run_write_word0", ins, 32'h00A0_0513);
    step(8);
    chk("rc_ten", rc, 32'd10);
    rst = 1; step(1); rst = 0;
    chk("midreset_ee", {31'd0, ee}, 32'd0);
    chk("midreset_rc", rc, 32'd0);
    chk("midreset_le", {31'd0, le}, 32'd0);
    chk("midreset_word0", ins, 32'h00A0_0513);
    btn = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin rst = 1; wen = 1; waddr = 5; wdat = 8'h9A; end
      step(1);
      rst = 0; wen = 0;
    end
    chk("rst_edge_ee", {31'd0, ee}, 32'd0);
    pc = 4; #1;
    chk("rst_edge_byte5", {24'd0, ins[15:8]}, 32'h0000_00C4);
    chk("rst_edge_byte4", {24'd0, ins[7:0]}, 32'h0000_00C3);
    step(5);
    chk("repress_early_ee", {31'd0, ee}, 32'd0);
    step(1);
    chk("repress_ee", {31'd0, ee}, 32'd1);
    btn = 0;
    pc = 2; #1;
    chk("run_misaligned", ins, 32'h0);
    pc = MB - 4; #1;
    chk("run_last", ins, 32'h1234_5678);
    step(20);
    chk("rc_twenty", rc, 32'd20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
